mem_ctrl_dp: RTL and testbench

MEM_CTRL_DP -- requirements
Module: mem_ctrl_dp

---
 rtl/mem_ctrl_dp_pkg.sv | 20 ++
 rtl/mem_ctrl_dp_rd_pipe.sv | 48 ++++
 rtl/mem_ctrl_dp.sv | 178 +++++++++++++++++
 tb/tb_mem_ctrl_dp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_dp_pkg.sv
// Shared definitions for the dual-port memory controller: controller state
// encoding and the supported read-latency range.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_t;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    // Out-of-range latencies are pulled to the nearest supported value.
    function automatic int unsigned clamp_latency(input int unsigned lat);
        if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
        if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_ctrl_dp_rd_pipe.sv
// Valid/data delay line for one read port. Data registers load only with a
// valid beat, so the output holds steady between pulses.
module mem_rd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld;
        logic [WIDTH-1:0] dat [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    dat[i] <= '0;
                end
            end else begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= in_data;
                end
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        dat[i] <= dat[i-1];
                    end
                end
            end
        end

        assign out_valid = vld[DEPTH-1];
        assign out_data  = dat[DEPTH-1];
    end

endmodule

// File: rtl/mem_ctrl_dp.sv
// Dual-port word memory: port A read-only, port B read/byte-masked write,
// read-first semantics, optional zero-fill sequence after reset.
module mem_ctrl_dp
  import mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE       = 8192,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter              INIT_FILE      = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_a,
  input  logic [$clog2(MEM_SIZE)-1:0] addr_a,
  output logic                        ready_a,
  output logic                        rvalid_a,
  output logic [DATA_WIDTH-1:0]       data_o_a,
  input  logic                        req_b,
  input  logic                        write_en_b,
  input  logic [$clog2(MEM_SIZE)-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0]       data_i_b,
  input  logic [DATA_WIDTH/8-1:0]     data_en_b,
  output logic                        ready_b,
  output logic                        rvalid_b,
  output logic [DATA_WIDTH-1:0]       data_o_b,
  output logic                        collision,
  output logic                        busy
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned AW         = $clog2(MEM_SIZE);
  localparam int unsigned OFF        = $clog2(BYTES);
  localparam int unsigned DEPTH      = MEM_SIZE / BYTES;
  localparam int unsigned IW         = AW - OFF;
  localparam int unsigned LAT        = clamp_latency(READ_LATENCY);
  localparam int unsigned PIPE_DEPTH = LAT - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  mem_state_t    state;
  mem_state_t    state_nxt;
  logic [IW-1:0] clr_idx;

  logic [IW-1:0] idx_a;
  logic [IW-1:0] idx_b;
  logic          acc_a;
  logic          acc_b;
  logic          col_hit;

  assign idx_a = addr_a[AW-1:OFF];
  assign idx_b = addr_b[AW-1:OFF];

  if (OFF > 0) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_a[OFF-1:0], addr_b[OFF-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        state <= ST_CLEAR;
      end else begin
        state <= ST_RUN;
      end
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    case (state)
      ST_CLEAR: busy = 1'b1;
      ST_RUN: begin
        ready_a = 1'b1;
        ready_b = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
    end
  end

  // Storage has no reset, so contents survive rst apart from the clear walk.
  assign acc_a   = req_a & ready_a;
  assign acc_b   = req_b & ready_b;
  assign col_hit = acc_a & acc_b & write_en_b & (idx_a == idx_b);

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (acc_b && write_en_b) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (data_en_b[i]) begin
          mem[idx_b][8*i +: 8] <= data_i_b[8*i +: 8];
        end
      end
    end
  end

  logic                  s0_vld_a;
  logic                  s0_col_a;
  logic [DATA_WIDTH-1:0] s0_dat_a;
  logic                  s0_vld_b;
  logic [DATA_WIDTH-1:0] s0_dat_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld_a <= 1'b0;
      s0_col_a <= 1'b0;
      s0_dat_a <= '0;
      s0_vld_b <= 1'b0;
      s0_dat_b <= '0;
    end else begin
      s0_vld_a <= acc_a;
      s0_vld_b <= acc_b;
      if (acc_a) begin
        s0_dat_a <= mem[idx_a];
        s0_col_a <= col_hit;
      end
      if (acc_b) begin
        s0_dat_b <= mem[idx_b];
      end
    end
  end

  // Collision flag travels with port A data so it lines up with rvalid_a.
  logic [DATA_WIDTH:0] pipe_dat_a;
  logic                pipe_vld_a;

  mem_rd_pipe #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (PIPE_DEPTH)
  ) u_rd_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s0_vld_a),
    .in_data   ({s0_col_a, s0_dat_a}),
    .out_valid (pipe_vld_a),
    .out_data  (pipe_dat_a)
  );

  mem_rd_pipe #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (PIPE_DEPTH)
  ) u_rd_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s0_vld_b),
    .in_data   (s0_dat_b),
    .out_valid (rvalid_b),
    .out_data  (data_o_b)
  );

  assign rvalid_a  = pipe_vld_a;
  assign data_o_a  = pipe_dat_a[DATA_WIDTH-1:0];
  assign collision = pipe_vld_a & pipe_dat_a[DATA_WIDTH];

endmodule

// File: tb/tb_mem_ctrl_dp.sv
// Scoreboard bench for mem_ctrl_dp: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_mem_ctrl_dp;

    localparam int unsigned MEM_SIZE = 64;
    localparam int unsigned DW       = 32;
    localparam int unsigned RL       = 2;
    localparam int unsigned BYTES    = DW / 8;
    localparam int unsigned DEPTH    = MEM_SIZE / BYTES;
    localparam int unsigned AW       = $clog2(MEM_SIZE);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic          ready_a;
    logic          rvalid_a;
    logic [DW-1:0] data_o_a;
    logic          req_b = 1'b0;
    logic          write_en_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] data_i_b = '0;
    logic [BYTES-1:0] data_en_b = '0;
    logic          ready_b;
    logic          rvalid_b;
    logic [DW-1:0] data_o_b;
    logic          collision;
    logic          busy;

    always #5 clk = ~clk;

    mem_ctrl_dp #(
        .MEM_SIZE       (MEM_SIZE),
        .DATA_WIDTH     (DW),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .addr_a     (addr_a),
        .ready_a    (ready_a),
        .rvalid_a   (rvalid_a),
        .data_o_a   (data_o_a),
        .req_b      (req_b),
        .write_en_b (write_en_b),
        .addr_b     (addr_b),
        .data_i_b   (data_i_b),
        .data_en_b  (data_en_b),
        .ready_b    (ready_b),
        .rvalid_b   (rvalid_b),
        .data_o_b   (data_o_b),
        .collision  (collision),
        .busy       (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          col;
        int unsigned   due;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] mem_m [DEPTH];
    int unsigned   clear_left = DEPTH;
    int unsigned   cyc = 0;
    int unsigned   ia;
    int unsigned   ib;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word array that is zeroed one word per cycle after
    // reset, then serves reads with the word as it was before this cycle's write.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            clear_left = DEPTH;
        end else if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = '0;
            clear_left--;
            cyc++;
        end else begin
            ia = addr_a / BYTES;
            ib = addr_b / BYTES;
            if (req_a)
                qa.push_back('{mem_m[ia], (req_b && write_en_b && ia == ib), cyc + RL});
            if (req_b) begin
                qb.push_back('{mem_m[ib], 1'b0, cyc + RL});
                if (write_en_b)
                    for (int k = 0; k < int'(BYTES); k++)
                        if (data_en_b[k]) mem_m[ib][8*k +: 8] = data_i_b[8*k +: 8];
            end
            cyc++;
        end
    end

    // Monitor: compares every cycle against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_a = '0;
            last_b = '0;
            check("rst_rvalid_a", 64'(rvalid_a), 64'(0));
            check("rst_rvalid_b", 64'(rvalid_b), 64'(0));
            check("rst_data_o_a", 64'(data_o_a), 64'(0));
            check("rst_data_o_b", 64'(data_o_b), 64'(0));
            check("rst_collision", 64'(collision), 64'(0));
            check("rst_busy", 64'(busy), 64'(1));
            check("rst_ready", 64'({ready_a, ready_b}), 64'(0));
        end else begin
            check("busy", 64'(busy), 64'(clear_left > 0));
            check("ready_a", 64'(ready_a), 64'(clear_left == 0));
            check("ready_b", 64'(ready_b), 64'(clear_left == 0));
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                check("rvalid_a", 64'(rvalid_a), 64'(1));
                check("data_o_a", 64'(data_o_a), 64'(e.data));
                check("collision", 64'(collision), 64'(e.col));
                last_a = e.data;
            end else begin
                check("rvalid_a_idle", 64'(rvalid_a), 64'(0));
                check("data_o_a_hold", 64'(data_o_a), 64'(last_a));
                check("collision_idle", 64'(collision), 64'(0));
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                check("rvalid_b", 64'(rvalid_b), 64'(1));
                check("data_o_b", 64'(data_o_b), 64'(e.data));
                last_b = e.data;
            end else begin
                check("rvalid_b_idle", 64'(rvalid_b), 64'(0));
                check("data_o_b_hold", 64'(data_o_b), 64'(last_b));
            end
        end
    end

    task automatic drive(input logic ra, input logic [AW-1:0] aa, input logic rb,
                         input logic we, input logic [AW-1:0] ab,
                         input logic [DW-1:0] db, input logic [BYTES-1:0] en);
        req_a      = ra;
        addr_a     = aa;
        req_b      = rb;
        write_en_b = we;
        addr_b     = ab;
        data_i_b   = db;
        data_en_b  = en;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Counts busy cycles after reset release; bounded so a stuck busy fails.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;

        // Clear after reset with req_a held: nothing accepted until RUN.
        req_a  = 1'b1;
        addr_a = AW'(20);
        rst    = 1'b0;
        count_busy(n);
        check("clear_busy_cycles", 64'(n), 64'(16));
        @(posedge clk);
        #2;
        req_a = 1'b0;
        idle(4);

        // Byte-masked write over a known word, then read back on A.
        drive(1'b0, '0, 1'b1, 1'b1, AW'(8), 32'h11223344, 4'hF);
        drive(1'b0, '0, 1'b1, 1'b1, AW'(8), 32'hDEADBEEF, 4'b0101);
        drive(1'b1, AW'(8), 1'b0, 1'b0, '0, '0, '0);
        // Write with no enables leaves the word untouched but still responds.
        drive(1'b0, '0, 1'b1, 1'b1, AW'(9), 32'hFFFFFFFF, 4'h0);
        drive(1'b1, AW'(11), 1'b1, 1'b0, AW'(8), '0, '0);
        idle(4);

        // Back-to-back A reads.
        drive(1'b0, '0, 1'b1, 1'b1, AW'(0), 32'h01010101, 4'hF);
        drive(1'b0, '0, 1'b1, 1'b1, AW'(4), 32'h02020202, 4'hF);
        drive(1'b1, AW'(0), 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, AW'(4), 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, AW'(8), 1'b0, 1'b0, '0, '0, '0);
        idle(4);

        // Same-word A read and B write in one cycle.
        drive(1'b0, '0, 1'b1, 1'b1, AW'(12), 32'h0, 4'hF);
        drive(1'b1, AW'(12), 1'b1, 1'b1, AW'(12), 32'hCAFEF00D, 4'hF);
        drive(1'b1, AW'(12), 1'b0, 1'b0, '0, '0, '0);
        idle(4);

        // Reset part-way through a clear restarts it from index 0.
        drive(1'b0, '0, 1'b1, 1'b1, AW'(12), 32'h33333333, 4'hF);
        drive(1'b0, '0, 1'b1, 1'b1, AW'(40), 32'hAAAAAAAA, 4'hF);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        count_busy(n);
        check("restart_busy_cycles", 64'(n), 64'(16));
        drive(1'b1, AW'(12), 1'b1, 1'b0, AW'(40), '0, '0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, MEM_SIZE - 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, MEM_SIZE - 1)), DW'($urandom),
                  BYTES'($urandom_range(0, 15)));
        end
        idle(6);

        check("qa_drained", 64'(qa.size()), 64'(0));
        check("qb_drained", 64'(qb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
